// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets and constants shared by the MMIO responder
package mmio_pkg;

   // Word offsets inside the 8-word window
   localparam logic [2:0] OFFS_LED    = 3'd0;
   localparam logic [2:0] OFFS_SW     = 3'd1;
   localparam logic [2:0] OFFS_TIMER  = 3'd2;
   localparam logic [2:0] OFFS_CMP    = 3'd3;
   localparam logic [2:0] OFFS_STATUS = 3'd4;
   localparam logic [2:0] OFFS_TXDATA = 3'd5;
   localparam logic [2:0] OFFS_TXSTAT = 3'd6;
   localparam logic [2:0] OFFS_RSVD   = 3'd7;

   // STATUS bit positions
   localparam int STAT_MATCH = 0;
   localparam int STAT_OVF   = 1;

   // CMP comes out of reset at all-ones so a fresh timer does not match early
   localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - byte transmit FIFO with push/pop, occupancy and masked head
module mmio_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [7:0]               data_i,
   output logic [7:0]               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

   // A pop frees the slot in the same edge, so a push while full is still taken then
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Stale entries are never exposed: the head reads zero while empty
   assign head_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents need no reset because the head is masked when empty
   always_ff @(negedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointer and occupancy registers on the bus (falling) edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - MMIO target: LED, switches, timer/compare, TX FIFO and RAM chip-select gating
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [6:0] BASE       = 7'h78,
   parameter int         FIFO_DEPTH = 4,
   parameter int         TIMER_DIV  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CS,
   input  logic        WE,
   input  logic [6:0]  ADDR,
   inout  wire  [31:0] Mem_Bus,
   output logic        mem_cs,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam logic [31:0] PRE_LAST = 32'(TIMER_DIV - 1);

   logic                       hit;
   logic [2:0]                 offs;
   logic                       wr;
   logic [31:0]                wdata;
   logic                       tick, timer_wr, push_req, fifo_pop;
   logic                       fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [1:0]                 hw_set, w1c;

   logic [7:0]  led_q, led_d;
   logic [31:0] dout_q, dout_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] cmp_q, cmp_d;
   logic [31:0] pre_q, pre_d;
   logic [1:0]  status_q, status_d;
   logic [7:0]  sync1_q, sync2_q;

   assign hit    = (ADDR[6:3] == BASE[6:3]);
   assign offs   = ADDR[2:0];
   assign wr     = CS & WE & hit;
   assign wdata  = Mem_Bus;
   assign mem_cs = CS & ~hit;

   // Drive the shared bus only for a read hit, and never while in reset
   assign Mem_Bus = (CS & ~WE & hit & ~RST) ? dout_q : 32'bz;

   assign led      = led_q;
   assign tx_valid = ~fifo_empty;
   assign fifo_pop = tx_valid & tx_ready;
   assign push_req = wr & (offs == OFFS_TXDATA);
   assign timer_wr = wr & (offs == OFFS_TIMER);
   assign tick     = (pre_q == PRE_LAST);

   mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push_i  (push_req),
      .pop_i   (fifo_pop),
      .data_i  (wdata[7:0]),
      .head_o  (tx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Next-state for registers, timer/prescaler, STATUS and the read-data mux
   always_comb begin
      led_d   = led_q;
      cmp_d   = cmp_q;
      timer_d = timer_q;
      pre_d   = pre_q + 32'd1;
      hw_set  = 2'b00;
      w1c     = 2'b00;

      if (wr && offs == OFFS_LED) led_d = wdata[7:0];
      if (wr && offs == OFFS_CMP) cmp_d = wdata;

      // A software load wins over the increment and restarts the prescaler
      if (timer_wr) begin
         timer_d = wdata;
         pre_d   = '0;
      end else if (tick) begin
         timer_d = timer_q + 32'd1;
         pre_d   = '0;
      end

      hw_set[STAT_MATCH] = tick & ~timer_wr & (timer_q == cmp_q);
      hw_set[STAT_OVF]   = push_req & fifo_full & ~fifo_pop;
      if (wr && offs == OFFS_STATUS) w1c = wdata[1:0];
      // Hardware set beats a same-cycle clear
      status_d = (status_q & ~w1c) | hw_set;

      case (offs)
         OFFS_LED:    dout_d = {24'd0, led_q};
         OFFS_SW:     dout_d = {24'd0, sync2_q};
         OFFS_TIMER:  dout_d = timer_q;
         OFFS_CMP:    dout_d = cmp_q;
         OFFS_STATUS: dout_d = {30'd0, status_q};
         OFFS_TXSTAT: dout_d = {22'd0, fifo_full, fifo_empty, 3'd0, 5'(fifo_count)};
         default:     dout_d = 32'd0;
      endcase
   end

   // All state updates on the falling edge to match the RAM bus timing
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         led_q    <= '0;
         dout_q   <= '0;
         timer_q  <= '0;
         cmp_q    <= CMP_RESET;
         pre_q    <= '0;
         status_q <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
      end else begin
         led_q    <= led_d;
         dout_q   <= dout_d;
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         pre_q    <= pre_d;
         status_q <= status_d;
         sync1_q  <= sw;
         sync2_q  <= sync1_q;
      end
   end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU memory bus (CS, WE, ADDR[6:0], Mem_Bus). The CPU is the bus initiator; this block is the second target beside the RAM and answers the top eight word addresses. It holds an LED register, synchronised switch inputs, a 32-bit timer with compare, and a byte transmit FIFO drained through a valid/ready handshake. It also produces the gated chip-select for the RAM so the two targets never drive Mem_Bus together.

## Interface
- BASE, 7'h78: first word address of the 8-word window; must be 8-aligned.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, 2..16.
- TIMER_DIV, 1: timer increments once every TIMER_DIV clocks; minimum 1.
- CLK  in  1  system clock; all flops on falling edge, matching RAM bus timing.
- RST  in  1  reset, asynchronous, active-high.
- CS  in  1  bus chip select from CPU.
- WE  in  1  bus write enable from CPU.
- ADDR  in  7  bus word address.
- Mem_Bus  inout  32  shared data bus; driven only on a read hit.
- mem_cs  out  1  RAM chip select = CS & ~hit.
- sw  in  8  asynchronous switch inputs.
- led  out  8  LED register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head byte this cycle.

## Operation
- hit = (ADDR[6:3] == BASE[6:3]); combinational. offs = ADDR[2:0].
- Register map (offs):
  - 0 LED, RW, [7:0].
  - 1 SW, RO, synced sw in [7:0].
  - 2 TIMER, RW, 32-bit.
  - 3 CMP, RW, 32-bit.
  - 4 STATUS: bit0 match, bit1 overflow; W1C.
  - 5 TXDATA, WO: push Mem_Bus[7:0]; reads 0.
  - 6 TXSTAT, RO: [4:0] count, bit8 empty, bit9 full.
  - 7 reserved: reads 0, writes ignored.
- Unused upper bits read 0.
- Write: CS&WE&hit at falling edge updates the addressed register.
- Read: at every falling edge, data_out <= selected register value, regardless of CS.
  - Mem_Bus = (CS & ~WE & hit) ? data_out : Z.
- Timer:
  - Prescale counter wraps at TIMER_DIV-1; TIMER increments on wrap.
  - TIMER wraps FFFFFFFF -> 0.
  - If TIMER == CMP on an increment tick, STATUS.match sets.
  - A TIMER write takes priority over the increment in the same cycle and clears the prescaler.
- STATUS: hardware set and W1C in the same cycle -> set wins.
- FIFO:
  - Push on a TXDATA write when not full.
  - A push while full is dropped and sets STATUS.overflow.
  - Pop when tx_valid & tx_ready.
  - Push and pop in the same cycle both execute, count unchanged; when full, this push is accepted (not overflow).
  - tx_data is undefined-free: shows 0 when empty.
- SW sync: two-flop synchroniser; SW reads return the second stage.

## Timing
- Reset values: led 0, data_out 0, TIMER 0, CMP FFFFFFFF, prescaler 0, STATUS 0, FIFO empty (count 0), tx_valid 0, tx_data 0, sync stages 0.
- Mem_Bus is Z during reset.
- Reset asserted mid-operation clears all state immediately; a pending write is lost.
- Read latency matches RAM: address stable before falling edge N, data on Mem_Bus after edge N, valid at rising edge N+1.
- Write effect is visible to a read whose address is presented at the next falling edge.
- tx_valid rises at the falling edge that pushes into an empty FIFO; it falls at the edge that pops the last entry with no simultaneous push.
- sw change appears in SW reads 2 falling edges later (third edge at worst).
- mem_cs is purely combinational; no added latency to RAM.

## Structure
- Package mmio_pkg: register offset constants (OFFS_LED..OFFS_TXSTAT), STATUS bit indices, CMP reset value.
- Sub-module mmio_tx_fifo: parameterised by DEPTH, with push/pop/full/empty/count and a head output. Pointers are log2(DEPTH) wide with wrap; count is log2(DEPTH)+1 wide.
- Top holds decode, registers, timer, synchroniser and bus tristate.

## Test plan
- Reset, then read offs 2,3,4,6 -> 0, FFFFFFFF, 0, 0x100; Mem_Bus Z while CS=0; read of ADDR 7'h10 -> mem_cs=1 and no drive.
- Write LED 0xA5 then read back -> led=8'hA5, read 0x000000A5; write to offs 7 then read -> 0.
- TIMER_DIV=1: write CMP=5, TIMER=3 -> match bit set at the tick from 5; W1C on STATUS in the same cycle as a set -> bit stays 1; TIMER=FFFFFFFF -> 0 next tick.
- tx_ready=0, push 5 bytes 0x11..0x15 -> count 4, full, overflow=1, head 0x11. Then tx_ready=1 -> drains 0x11..0x14 in order, then tx_valid=0.
- FIFO full with push+pop in the same cycle -> count stays 4, overflow stays 0, new byte at tail.
- sw=0x3C async -> SW read 0x3C within 3 falling edges; RST pulse mid-FIFO-drain -> tx_valid=0, count 0 immediately.
